// File: rtl/lb_test_ctrl_if.sv
// Loopback tester attachment: PRBS/RX reset controls out, tester counters and latency in.
// Latency: none, wiring only.
// Backpressure: none; level signals sampled every cycle.
interface lb_test_ctrl_if #(
  parameter int LAT_W = 8
);
  logic             prbs_rst_o;
  logic             rx_rstb_o;
  logic [1:0]       lb_mode_o;
  logic [63:0]      lb_correct_bits_i;
  logic [63:0]      lb_total_bits_i;
  logic [LAT_W-1:0] lb_latency_i;

  // Sequencer side drives the resets/mode and watches the tester.
  modport master (
    output prbs_rst_o, rx_rstb_o, lb_mode_o,
    input  lb_correct_bits_i, lb_total_bits_i, lb_latency_i
  );

  // Loopback tester side.
  modport slave (
    input  prbs_rst_o, rx_rstb_o, lb_mode_o,
    output lb_correct_bits_i, lb_total_bits_i, lb_latency_i
  );
endinterface

// File: rtl/lb_test_ctrl.sv
// PRBS loopback BER run sequencer: RESET -> SETTLE -> ALIGN -> MEASURE -> DONE with pass/fail vs threshold.
// Latency: start to done_o is at least 1+RST_CYCLES+SETTLE_CYCLES+STABLE_CYCLES+1 cycles; all outputs registered.
// Backpressure: none; start_i honoured only in IDLE/DONE, abort_i wins everywhere. Option macro: LB_TEST_CTRL_STALL_DET_EN.
module lb_test_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int ALIGN_TIMEOUT = 4096,
  parameter int LAT_W         = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] n_bits_i,
  input  logic [63:0] err_thresh_i,
  lb_test_ctrl_if.master lb,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [63:0] err_count_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_SETTLE  = 3'd2,
    S_ALIGN   = 3'd3,
    S_MEASURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [31:0] LP_RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LP_SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] LP_STABLE      = 32'(STABLE_CYCLES);
  localparam logic [31:0] LP_TIMEOUT     = 32'(ALIGN_TIMEOUT);

  state_t           r_state, w_state_nxt;
  // Phase counter: cycle count in RESET/SETTLE, timeout count in ALIGN, stall count in MEASURE.
  logic [31:0]      r_cnt, w_cnt_nxt;
  logic [31:0]      r_stable, w_stable_nxt;
  logic [LAT_W-1:0] r_prev_lat;
  logic [63:0]      r_n_bits, w_n_bits_nxt;
  logic [63:0]      r_thresh, w_thresh_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [63:0]      r_err, w_err_nxt;
  logic             r_prbs_rst, w_prbs_rst_nxt;
  logic             r_rx_rstb, w_rx_rstb_nxt;
  logic [1:0]       r_lb_mode, w_lb_mode_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

  logic [63:0]      w_err_calc;
  logic [31:0]      w_stable_inc;
  logic [31:0]      w_to_inc;

  // Error count saturates at zero if the tester ever reports more correct than total bits.
  assign w_err_calc   = (lb.lb_total_bits_i >= lb.lb_correct_bits_i) ?
                        (lb.lb_total_bits_i - lb.lb_correct_bits_i) : 64'd0;
  // Any latency change restarts the run of stable cycles at 1.
  assign w_stable_inc = (lb.lb_latency_i != r_prev_lat) ? 32'd1 : (r_stable + 32'd1);
  assign w_to_inc     = r_cnt + 32'd1;

`ifdef LB_TEST_CTRL_STALL_DET_EN
  logic [63:0] r_prev_total;
  logic [31:0] w_stall_inc;
  assign w_stall_inc = (lb.lb_total_bits_i != r_prev_total) ? 32'd0 : (r_cnt + 32'd1);

  // Track the tester's total-bit count to spot a stalled measurement.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_prev_total <= '0;
    else       r_prev_total <= lb.lb_total_bits_i;
  end
`endif

  // Next-state, counters, results and the registered output image of the next state.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stable_nxt  = r_stable;
    w_n_bits_nxt  = r_n_bits;
    w_thresh_nxt  = r_thresh;
    w_pass_nxt    = r_pass;
    w_timeout_nxt = r_timeout;
    w_err_nxt     = r_err;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_nxt   = S_RESET;
          w_cnt_nxt     = '0;
          w_n_bits_nxt  = n_bits_i;
          w_thresh_nxt  = err_thresh_i;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_err_nxt     = '0;
        end
      end
      S_RESET: begin
        if (r_cnt == LP_RST_LAST) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == LP_SETTLE_LAST) begin
          w_state_nxt  = S_ALIGN;
          w_cnt_nxt    = '0;
          w_stable_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      S_ALIGN: begin
        w_stable_nxt = w_stable_inc;
        w_cnt_nxt    = w_to_inc;
        // Lock is tested first so it wins a same-cycle timeout.
        if (w_stable_inc == LP_STABLE) begin
          w_state_nxt = S_MEASURE;
          w_cnt_nxt   = '0;
        end else if (w_to_inc == LP_TIMEOUT) begin
          w_state_nxt   = S_DONE;
          w_timeout_nxt = 1'b1;
          w_pass_nxt    = 1'b0;
          w_err_nxt     = '0;
        end
      end
      S_MEASURE: begin
`ifdef LB_TEST_CTRL_STALL_DET_EN
        w_cnt_nxt = w_stall_inc;
`endif
        if (lb.lb_total_bits_i >= r_n_bits) begin
          w_state_nxt   = S_DONE;
          w_err_nxt     = w_err_calc;
          w_pass_nxt    = (w_err_calc <= r_thresh);
          w_timeout_nxt = 1'b0;
        end
`ifdef LB_TEST_CTRL_STALL_DET_EN
        else if (w_stall_inc == 32'd256) begin
          w_state_nxt   = S_DONE;
          w_err_nxt     = w_err_calc;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
        end
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (abort_i) begin
      w_state_nxt   = S_IDLE;
      w_cnt_nxt     = '0;
      w_pass_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      w_err_nxt     = '0;
    end

    w_prbs_rst_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RESET);
    w_rx_rstb_nxt  = ~w_prbs_rst_nxt;
    w_busy_nxt     = (w_state_nxt == S_RESET) || (w_state_nxt == S_SETTLE) ||
                     (w_state_nxt == S_ALIGN) || (w_state_nxt == S_MEASURE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    case (w_state_nxt)
      S_ALIGN:   w_lb_mode_nxt = 2'b01;
      S_MEASURE: w_lb_mode_nxt = 2'b10;
      S_DONE:    w_lb_mode_nxt = 2'b11;
      default:   w_lb_mode_nxt = 2'b00;
    endcase
  end

  // State, counters, latched run parameters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_stable   <= '0;
      r_prev_lat <= '0;
      r_n_bits   <= '0;
      r_thresh   <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_err      <= '0;
      r_prbs_rst <= 1'b1;
      r_rx_rstb  <= 1'b0;
      r_lb_mode  <= 2'b00;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_stable   <= w_stable_nxt;
      r_prev_lat <= lb.lb_latency_i;
      r_n_bits   <= w_n_bits_nxt;
      r_thresh   <= w_thresh_nxt;
      r_pass     <= w_pass_nxt;
      r_timeout  <= w_timeout_nxt;
      r_err      <= w_err_nxt;
      r_prbs_rst <= w_prbs_rst_nxt;
      r_rx_rstb  <= w_rx_rstb_nxt;
      r_lb_mode  <= w_lb_mode_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign lb.prbs_rst_o = r_prbs_rst;
  assign lb.rx_rstb_o  = r_rx_rstb;
  assign lb.lb_mode_o  = r_lb_mode;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign pass_o        = r_pass;
  assign timeout_o     = r_timeout;
  assign err_count_o   = r_err;
  assign state_o       = r_state;

endmodule

// File: tb/tb_lb_test_ctrl.sv
// Directed bench for lb_test_ctrl with a simple loopback tester model driven each cycle.
// Latency: phase lengths measured in cycles and compared against hand-computed values.
// Backpressure: none; every wait is bounded by a cycle budget.
module tb_lb_test_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort;
  logic [63:0] n_bits, thresh;
  logic        busy, done, pass, tmo;
  logic [63:0] err;
  logic [2:0]  st;

  lb_test_ctrl_if #(.LAT_W(8)) lb_if();

  lb_test_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .n_bits_i     (n_bits),
    .err_thresh_i (thresh),
    .lb           (lb_if),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .timeout_o    (tmo),
    .err_count_o  (err),
    .state_o      (st)
  );

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [63:0] total;
  logic [63:0] err_inj;
  logic [63:0] corr_extra;
  bit          toggle_en;
  int          tog_cnt;
  logic [7:0]  lat;
  int          n;

  // Tester model: correct = total - err_inj (floored at 0), or total + corr_extra when set.
  task automatic drive_tester();
    lb_if.lb_total_bits_i = total;
    if (corr_extra != 64'd0)
      lb_if.lb_correct_bits_i = total + corr_extra;
    else
      lb_if.lb_correct_bits_i = (total > err_inj) ? (total - err_inj) : 64'd0;
    lb_if.lb_latency_i = lat;
  endtask

  // Advance one clock; the tester clears in CLEAR mode and counts one bit per cycle in TEST mode.
  task automatic tick();
    @(posedge clk);
    #1;
    if (lb_if.lb_mode_o == 2'b00)      total = 64'd0;
    else if (lb_if.lb_mode_o == 2'b10) total = total + 64'd1;
    tog_cnt++;
    if (toggle_en && (tog_cnt % 10 == 0)) lat = lat ^ 8'd1;
    drive_tester();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Count cycles spent in state s, bounded by budget.
  task automatic run_in(input logic [2:0] s, input int budget, output int cnt);
    cnt = 0;
    while (st == s && cnt < budget) begin
      tick();
      cnt++;
    end
  endtask

  task automatic do_start(input logic [63:0] nb, input logic [63:0] th);
    start  = 1'b1;
    n_bits = nb;
    thresh = th;
    tick();
    start  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; n_bits = '0; thresh = '0;
    total = '0; err_inj = '0; corr_extra = '0; toggle_en = 1'b0; tog_cnt = 0; lat = 8'd5;
    drive_tester();
    repeat (3) tick();
    rst = 1'b0;

    // Reset values
    chk("rst_state", 64'(st), 64'd0);
    chk("rst_prbs", 64'(lb_if.prbs_rst_o), 64'd1);
    chk("rst_rxrstb", 64'(lb_if.rx_rstb_o), 64'd0);
    chk("rst_mode", 64'(lb_if.lb_mode_o), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", err, 64'd0);
    tick();

    // Clean run
    do_start(64'd1000, 64'd0);
    chk("clean_st_reset", 64'(st), 64'd1);
    chk("clean_busy", 64'(busy), 64'd1);
    run_in(3'd1, 100, n);
    chk("clean_reset_len", 64'(n), 64'd16);
    chk("clean_st_settle", 64'(st), 64'd2);
    chk("settle_prbs", 64'(lb_if.prbs_rst_o), 64'd0);
    chk("settle_rxrstb", 64'(lb_if.rx_rstb_o), 64'd1);
    run_in(3'd2, 2000, n);
    chk("clean_settle_len", 64'(n), 64'd1024);
    chk("align_mode", 64'(lb_if.lb_mode_o), 64'd1);
    run_in(3'd3, 5000, n);
    chk("clean_align_len", 64'(n), 64'd64);
    chk("measure_mode", 64'(lb_if.lb_mode_o), 64'd2);
    run_in(3'd4, 3000, n);
    chk("clean_measure_len", 64'(n), 64'd1000);
    chk("clean_st_done", 64'(st), 64'd5);
    chk("clean_done", 64'(done), 64'd1);
    chk("clean_pass", 64'(pass), 64'd1);
    chk("clean_err", err, 64'd0);
    chk("clean_tmo", 64'(tmo), 64'd0);
    chk("done_mode", 64'(lb_if.lb_mode_o), 64'd3);
    chk("done_busy", 64'(busy), 64'd0);
    repeat (3) tick();
    chk("clean_done_held", 64'(done), 64'd1);

    // Fail run, started from DONE
    err_inj = 64'd5;
    do_start(64'd1000, 64'd3);
    chk("fail_done_clr", 64'(done), 64'd0);
    run_in(3'd1, 100, n);
    run_in(3'd2, 2000, n);
    run_in(3'd3, 5000, n);
    run_in(3'd4, 3000, n);
    chk("fail_st_done", 64'(st), 64'd5);
    chk("fail_err", err, 64'd5);
    chk("fail_pass", 64'(pass), 64'd0);

    // Rerun with threshold 5
    do_start(64'd1000, 64'd5);
    run_in(3'd1, 100, n);
    run_in(3'd2, 2000, n);
    run_in(3'd3, 5000, n);
    run_in(3'd4, 3000, n);
    chk("rerun_st_done", 64'(st), 64'd5);
    chk("rerun_err", err, 64'd5);
    chk("rerun_pass", 64'(pass), 64'd1);

    // Alignment timeout: latency toggles every 10 cycles
    err_inj = 64'd0;
    toggle_en = 1'b1;
    do_start(64'd1000, 64'd0);
    run_in(3'd1, 100, n);
    run_in(3'd2, 2000, n);
    run_in(3'd3, 5000, n);
    chk("tmo_align_len", 64'(n), 64'd4096);
    chk("tmo_st_done", 64'(st), 64'd5);
    chk("tmo_flag", 64'(tmo), 64'd1);
    chk("tmo_pass", 64'(pass), 64'd0);
    chk("tmo_err", err, 64'd0);
    toggle_en = 1'b0;

    // Abort from DONE clears results
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_st", 64'(st), 64'd0);
    chk("abort_done_tmo", 64'(tmo), 64'd0);
    chk("abort_done_done", 64'(done), 64'd0);

    // Abort and start together in SETTLE
    do_start(64'd1000, 64'd0);
    run_in(3'd1, 100, n);
    repeat (3) tick();
    chk("coll_pre_st", 64'(st), 64'd2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("coll_st", 64'(st), 64'd0);
    chk("coll_busy", 64'(busy), 64'd0);
    chk("coll_prbs", 64'(lb_if.prbs_rst_o), 64'd1);

    // start ignored in MEASURE, then synchronous reset mid-MEASURE
    do_start(64'd1000, 64'd0);
    run_in(3'd1, 100, n);
    run_in(3'd2, 2000, n);
    run_in(3'd3, 5000, n);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("meas_start_ign1", 64'(st), 64'd4);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("meas_start_ign2", 64'(st), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_st", 64'(st), 64'd0);
    chk("midrst_prbs", 64'(lb_if.prbs_rst_o), 64'd1);
    chk("midrst_rxrstb", 64'(lb_if.rx_rstb_o), 64'd0);
    chk("midrst_mode", 64'(lb_if.lb_mode_o), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);

    // n_bits = 0, with correct > total (error saturates to 0)
    corr_extra = 64'd7;
    tick();
    do_start(64'd0, 64'd0);
    run_in(3'd1, 100, n);
    run_in(3'd2, 2000, n);
    run_in(3'd3, 5000, n);
    chk("zero_align_len", 64'(n), 64'd64);
    run_in(3'd4, 10, n);
    chk("zero_measure_len", 64'(n), 64'd1);
    chk("zero_st_done", 64'(st), 64'd5);
    chk("zero_pass", 64'(pass), 64'd1);
    chk("zero_err", err, 64'd0);
    corr_extra = 64'd0;

    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("final_abort_st", 64'(st), 64'd0);
    chk("final_abort_pass", 64'(pass), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
